// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states,
// byte-enabled stores and an out-of-range error response.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic                busy_o
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                accept, do_acc, hs, in_range;
  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   mem [0:(1<<IW)-1];
  always_comb begin
    idx      = addr_q[IW-1:0];
    in_range = {1'b0, addr_q} < DEPTH_L;
    accept   = state_q == S_IDLE && ready_q && req_valid_i;
    do_acc   = state_q == S_WAIT && cnt_q == 4'd0;
    hs       = state_q == S_RESP && resp_ready_i;
    state_d  = accept ? S_WAIT : do_acc ? S_RESP : hs ? S_IDLE : state_q;
    cnt_d    = accept ? WAIT_CYCLES[3:0] : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    write_d  = accept ? req_write_i : write_q;
    addr_d   = accept ? req_addr_i : addr_q;
    wdata_d  = accept ? req_wdata_i : wdata_q;
    be_d     = accept ? req_be_i : be_q;
    rdata_d  = do_acc ? ((!write_q && in_range) ? mem[idx] : '0) : hs ? '0 : rdata_q;
    err_d    = do_acc ? !in_range : hs ? 1'b0 : err_q;
    valid_d  = state_d == S_RESP;
    ready_d  = state_d == S_IDLE;
    busy_d   = state_d != S_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end
  // storage survives reset; a reset before the access edge leaves state IDLE so nothing commits
  always_ff @(posedge clk_i) begin
    if (do_acc && write_q && in_range)
      for (int k = 0; k < BE_W; k++)
        if (be_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
  end
  assign req_ready_o  = ready_q;
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, corner-case sequences and randomized traffic
// against an array model; a second instance covers zero wait states.
module tb_dmem_responder;
  logic        clk = 1'b0, rst_i = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [7:0]  req_addr = '0, req_be = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;
  logic        b_valid = 1'b0, b_rready = 1'b1;
  logic [7:0]  b_addr = 8'd3;
  logic        b_ready, b_rvalid, b_err, b_busy;
  logic [63:0] b_rdata;
  int n_chk = 0, n_fail = 0;
  logic [63:0] mm [0:255];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(64), .DEPTH(200), .WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .busy_o(busy));

  dmem_responder #(.ADDR_W(8), .DATA_W(64), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_write_i(1'b0), .req_addr_i(b_addr), .req_wdata_i(64'd0), .req_be_i(8'd0),
    .resp_valid_o(b_rvalid), .resp_ready_i(b_rready), .resp_rdata_o(b_rdata),
    .resp_err_o(b_err), .busy_o(b_busy));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [7:0] a, input logic [63:0] d, input logic [7:0] be,
                     output logic [63:0] rd, output logic er, output int lat, output logic quiet);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; quiet = 1'b1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1 lat++;
      if (!resp_valid && (req_ready || !busy)) quiet = 1'b0;
    end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    chk("valid_drop", {63'd0, resp_valid}, 64'd0);
  endtask

  task automatic run(input string nm, input logic w, input logic [7:0] a, input logic [63:0] d,
                     input logic [7:0] be, input logic [63:0] er_exp, input logic ee_exp);
    logic [63:0] rd; logic er, q; int lat;
    txn(w, a, d, be, rd, er, lat, q);
    chk({nm, "_rdata"}, rd, er_exp);
    chk({nm, "_err"}, {63'd0, er}, {63'd0, ee_exp});
    chk({nm, "_lat"}, 64'(lat), 64'd3);
    chk({nm, "_ready_busy"}, {63'd0, q}, 64'd1);
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] r = old;
    for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  typedef struct { logic w; logic [7:0] a; logic [63:0] d; logic [7:0] be; logic [63:0] er; logic ee; } vec_t;
  vec_t tbl [0:7];

  initial begin
    logic [63:0] hold_rd; logic hold_er;
    int acc [$];
    logic rdy [0:19], rv [0:19];
    tbl[0] = '{1'b0, 8'd5,   64'd0,                  8'h00, 64'h1122334455667788, 1'b0};
    tbl[1] = '{1'b1, 8'd5,   64'hAAAAAAAAAAAAAAAA,   8'h0F, 64'd0,                1'b0};
    tbl[2] = '{1'b0, 8'd5,   64'd0,                  8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tbl[3] = '{1'b0, 8'd200, 64'd0,                  8'h00, 64'd0,                1'b1};
    tbl[4] = '{1'b1, 8'd250, 64'h5555555555555555,   8'hFF, 64'd0,                1'b1};
    tbl[5] = '{1'b0, 8'd199, 64'd0,                  8'h00, 64'h0123456789ABCDEF, 1'b0};
    tbl[6] = '{1'b1, 8'd7,   64'hFFFFFFFFFFFFFFFF,   8'h00, 64'd0,                1'b0};
    tbl[7] = '{1'b0, 8'd7,   64'd0,                  8'h00, 64'h0707070707070707, 1'b0};
    for (int i = 0; i < 256; i++) mm[i] = {$urandom, $urandom};
    mm[5] = 64'h1122334455667788; mm[7] = 64'h0707070707070707; mm[199] = 64'h0123456789ABCDEF;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err",   {63'd0, resp_err}, 64'd0);
    rst_i = 1'b1;
    #1 chk("rel_ready_before_edge", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1 chk("rel_ready_after_edge", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 200; i++) run("init", 1'b1, 8'(i), mm[i], 8'hFF, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].er, tbl[i].ee);
      if (tbl[i].w && tbl[i].a < 200) mm[tbl[i].a] = merge(mm[tbl[i].a], tbl[i].d, tbl[i].be);
    end
    // backpressure: response held, a request pulse in the meantime must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("bp_valid_rise", {63'd0, resp_valid}, 64'd1);
    hold_rd = resp_rdata; hold_er = resp_err;
    chk("bp_rdata", hold_rd, 64'h11223344AAAAAAAA);
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 1); req_write = 1'b1; req_wdata = '0; req_be = 8'hFF;
      @(posedge clk); #1;
      chk("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_hold_rdata", resp_rdata, 64'h11223344AAAAAAAA);
      chk("bp_hold_err", {63'd0, resp_err}, 64'd0);
      chk("bp_hold_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    chk("bp_done_valid", {63'd0, resp_valid}, 64'd0);
    chk("bp_done_ready", {63'd0, req_ready}, 64'd1);
    chk("bp_done_rdata", resp_rdata, 64'd0);
    run("bp_after", 1'b0, 8'd5, 64'd0, 8'h00, mm[5], 1'b0);
    // reset during WAIT of a store: nothing commits
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd7; req_wdata = 64'hDEADDEADDEADDEAD; req_be = 8'hFF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
    #1;
    chk("rw_valid", {63'd0, resp_valid}, 64'd0);
    chk("rw_busy", {63'd0, busy}, 64'd0);
    chk("rw_ready", {63'd0, req_ready}, 64'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    run("rw_load7", 1'b0, 8'd7, 64'd0, 8'h00, 64'h0707070707070707, 1'b0);
    // reset in RESP: the committed store survives
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd9; req_wdata = 64'hC0FFEE0012345678; req_be = 8'h3C;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rr_valid_before", {63'd0, resp_valid}, 64'd1);
    rst_i = 1'b0;
    #1 chk("rr_valid_after", {63'd0, resp_valid}, 64'd0);
    mm[9] = merge(mm[9], 64'hC0FFEE0012345678, 8'h3C);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    run("rr_load9", 1'b0, 8'd9, 64'd0, 8'h00, mm[9], 1'b0);
    // randomized traffic against the array model
    for (int i = 0; i < 150; i++) begin
      logic w; logic [7:0] a, be; logic [63:0] d, er; logic ee;
      w = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 215));
      d = {$urandom, $urandom}; be = 8'($urandom);
      ee = a >= 200;
      er = (w || ee) ? 64'd0 : mm[a];
      run("rand", w, a, d, be, er, ee);
      if (w && !ee) mm[a] = merge(mm[a], d, be);
    end
    // zero wait states, back-to-back loads with the response always accepted
    @(negedge clk);
    b_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      rdy[t] = b_ready; rv[t] = b_rvalid;
      if (rdy[t]) acc.push_back(t);
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("w0_accept_count", 64'(acc.size() >= 4), 64'd1);
    for (int i = 0; i < acc.size(); i++) begin
      if (acc[i] + 2 < 20) begin
        chk("w0_resp_next", {63'd0, rv[acc[i] + 2]}, 64'd1);
        chk("w0_not_early", {63'd0, rv[acc[i] + 1]}, 64'd0);
      end
      if (i > 0) chk("w0_spacing", 64'(acc[i] - acc[i-1]), 64'd3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
